// File: rtl/poly_eval_horner_pkg.sv
// Shared definitions for the Horner polynomial evaluator.
//   state_e  : controller states (3-bit encoding)
//   alu_op_e : operation selected on the shared datapath ALU
package poly_eval_horner_pkg;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_WAIT = 3'd1,
    ST_INIT = 3'd2,
    ST_MUL  = 3'd3,
    ST_ADD  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } alu_op_e;

endpackage

// File: rtl/poly_eval_horner_datapath.sv
// Datapath for poly_eval_horner: operand storage, accumulator, one shared
// WIDTH-bit add/multiply ALU (results truncated mod 2^WIDTH), and the
// result register.
// Ports:
//   clk, resetn  : clock, synchronous active-low reset (clears all registers)
//   data_in      : operand value written when wr_en is high
//   wr_en/wr_sel : write data_in into operand wr_sel (0..DEGREE = coef, DEGREE+1 = x)
//   acc_init     : acc <= coef[DEGREE]
//   acc_en       : acc <= ALU result
//   alu_op       : OP_MUL (acc*x) or OP_ADD (acc + coef[coef_sel])
//   coef_sel     : coefficient feeding the adder
//   res_en       : data_result <= ALU result
//   data_result  : last completed result
module poly_horner_datapath
  import poly_eval_horner_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2,
  parameter int IW     = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_sel,
  input  logic             acc_init,
  input  logic             acc_en,
  input  alu_op_e          alu_op,
  input  logic [IW-1:0]    coef_sel,
  input  logic             res_en,
  output logic [WIDTH-1:0] data_result
);

  localparam int unsigned NCOEF = DEGREE + 1;

  logic [WIDTH-1:0] coef_q [NCOEF];
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] coef_b;
  logic [WIDTH-1:0] alu_y;

  // Compare-based select keeps the index width independent of the array size.
  always_comb begin
    coef_b = '0;
    for (int unsigned k = 0; k < NCOEF; k++) begin
      if (coef_sel == IW'(k)) coef_b = coef_q[k];
    end
  end

  // Single ALU; WIDTH-bit operands and result give the wrap-around for free.
  always_comb begin
    if (alu_op == OP_MUL) alu_y = acc_q * x_q;
    else                  alu_y = acc_q + coef_b;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < NCOEF; k++) coef_q[k] <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      if (wr_en) begin
        for (int unsigned k = 0; k < NCOEF; k++) begin
          if (wr_sel == IW'(k)) coef_q[k] <= data_in;
        end
        if (wr_sel == IW'(DEGREE + 1)) x_q <= data_in;
      end
      if (acc_init)    acc_q <= coef_q[DEGREE];
      else if (acc_en) acc_q <= alu_y;
      if (res_en) result_q <= alu_y;
    end
  end

  assign data_result = result_q;

endmodule

// File: rtl/poly_eval_horner.sv
// Sequential polynomial evaluator y = c0 + c1*x + ... + cD*x^D (mod 2^WIDTH)
// using Horner's method on one shared add/multiply datapath. Operands
// c0..cD then x are keyed in one per go press.
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   go           : level input; a press is a rise then a fall
//   data_in      : operand value, captured on the LOAD cycle go is seen high
//   load_index   : operand awaited (0..D = c0..cD, D+1 = x)
//   busy         : high in INIT/MUL/ADD/DONE
//   done         : one-cycle strobe in DONE; data_result already valid
//   data_result  : last completed result, held until the next DONE
module poly_eval_horner
  import poly_eval_horner_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          go,
  input  logic [WIDTH-1:0]              data_in,
  output logic [$clog2(DEGREE+2)-1:0]   load_index,
  output logic                          busy,
  output logic                          done,
  output logic [WIDTH-1:0]              data_result
);

  localparam int IW = $clog2(DEGREE + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEGREE + 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] i_q, i_d;

  logic    wr_en;
  logic    acc_init;
  logic    acc_en;
  logic    res_en;
  alu_op_e alu_op;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      i_q     <= i_d;
    end
  end

  // acc_en separates accumulator writeback from res_en, so the final ADD
  // writes only the result register.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    i_d      = i_q;
    wr_en    = 1'b0;
    acc_init = 1'b0;
    acc_en   = 1'b0;
    res_en   = 1'b0;
    alu_op   = OP_ADD;
    unique case (state_q)
      ST_LOAD: begin
        if (go) begin
          wr_en   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!go) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_INIT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_INIT: begin
        acc_init = 1'b1;
        i_d      = IW'(DEGREE - 1);
        state_d  = ST_MUL;
      end
      ST_MUL: begin
        alu_op  = OP_MUL;
        acc_en  = 1'b1;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        alu_op = OP_ADD;
        if (i_q == '0) begin
          res_en  = 1'b1;
          state_d = ST_DONE;
        end else begin
          acc_en  = 1'b1;
          i_d     = i_q - 1'b1;
          state_d = ST_MUL;
        end
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign load_index = idx_q;
  assign busy       = (state_q == ST_INIT) || (state_q == ST_MUL) ||
                      (state_q == ST_ADD)  || (state_q == ST_DONE);
  assign done       = (state_q == ST_DONE);

  poly_horner_datapath #(
    .WIDTH  (WIDTH),
    .DEGREE (DEGREE),
    .IW     (IW)
  ) u_datapath (
    .clk         (clk),
    .resetn      (resetn),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .wr_sel      (idx_q),
    .acc_init    (acc_init),
    .acc_en      (acc_en),
    .alu_op      (alu_op),
    .coef_sel    (i_q),
    .res_en      (res_en),
    .data_result (data_result)
  );

endmodule

// File: tb/tb_poly_eval_horner.sv
module tb_poly_eval_horner;

  logic       clk = 1'b0;
  logic       resetn;
  logic       go2, go3;
  logic [7:0] din2, din3;
  logic [1:0] li2;
  logic [2:0] li3;
  logic       busy2, busy3, done2, done3;
  logic [7:0] res2, res3;

  always #5 clk = ~clk;

  poly_eval_horner #(.WIDTH(8), .DEGREE(2)) dut2 (
    .clk(clk), .resetn(resetn), .go(go2), .data_in(din2),
    .load_index(li2), .busy(busy2), .done(done2), .data_result(res2)
  );

  poly_eval_horner #(.WIDTH(8), .DEGREE(3)) dut3 (
    .clk(clk), .resetn(resetn), .go(go3), .data_in(din3),
    .load_index(li3), .busy(busy3), .done(done3), .data_result(res3)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] q2[$];
  logic [7:0] q3[$];
  logic [7:0] last2 = 8'd0, last3 = 8'd0;
  bit         mon_en = 1'b0;
  int         cv[16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: direct power-sum, reduced mod 256 term by term.
  function automatic logic [7:0] ref_poly(input int deg, input int x);
    longint sum = 0;
    longint pw  = 1;
    for (int k = 0; k <= deg; k++) begin
      sum = (sum + longint'(cv[k] % 256) * pw) % 256;
      pw  = (pw * longint'(x % 256)) % 256;
    end
    return 8'(sum);
  endfunction

  function automatic int cur_idx(input int d);
    return (d == 0) ? int'(li2) : int'(li3);
  endfunction
  function automatic int cur_busy(input int d);
    return (d == 0) ? int'(busy2) : int'(busy3);
  endfunction
  function automatic int cur_done(input int d);
    return (d == 0) ? int'(done2) : int'(done3);
  endfunction

  task automatic set_go(input int d, input logic g, input logic [7:0] v);
    if (d == 0) begin go2 = g; din2 = v; end
    else        begin go3 = g; din3 = v; end
  endtask

  task automatic set_c(input int a, input int b, input int c, input int e);
    for (int k = 0; k < 16; k++) cv[k] = 0;
    cv[0] = a; cv[1] = b; cv[2] = c; cv[3] = e;
  endtask

  task automatic press(input int d, input int k, input logic [7:0] v,
                       input int hold, input int gap);
    @(posedge clk); #1;
    check("load_index", cur_idx(d), k);
    check("busy_in_load", cur_busy(d), 0);
    set_go(d, 1'b1, v);
    repeat (hold) @(posedge clk);
    #1;
    check("busy_in_wait", cur_busy(d), 0);
    set_go(d, 1'b0, 8'($urandom));
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while ((cur_busy(d) != 0 || cur_idx(d) != 0) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (cur_done(d) == 0 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check("done_seen", cur_done(d), 1);
    @(posedge clk); #1;
  endtask

  // exp < 0 means use the reference model.
  task automatic run(input int d, input int x, input int exp,
                     input int hold_c0, input bit toggle);
    int deg = (d == 0) ? 2 : 3;
    logic [7:0] e;
    wait_idle(d);
    for (int k = 0; k <= deg; k++)
      press(d, k, 8'(cv[k]), (k == 0) ? hold_c0 : int'($urandom_range(1, 3)),
            int'($urandom_range(1, 3)));
    press(d, deg + 1, 8'(x), int'($urandom_range(1, 3)),
          toggle ? 0 : int'($urandom_range(0, 2)));
    e = (exp < 0) ? ref_poly(deg, x) : 8'(exp);
    if (d == 0) q2.push_back(e); else q3.push_back(e);
    if (toggle) begin
      for (int t = 0; t < 4; t++) begin
        @(posedge clk); #1;
        set_go(d, (t % 2 == 0), 8'($urandom));
      end
    end
    wait_done(d);
  endtask

  // Scoreboard monitor
  int cyc = 0;
  int tinit2 = 0, tinit3 = 0;
  logic pb2 = 1'b0, pb3 = 1'b0, pd2 = 1'b0, pd3 = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (busy2 && !pb2) tinit2 = cyc;
      if (busy3 && !pb3) tinit3 = cyc;
      if (done2) begin
        if (pd2) check("done2_one_cycle", 1, 0);
        check("latency2", cyc - tinit2, 5);
        if (q2.size() == 0) check("unexpected_done2", 1, 0);
        else begin
          last2 = q2.pop_front();
          check("result2", int'(res2), int'(last2));
        end
      end else check("hold2", int'(res2), int'(last2));
      if (done3) begin
        if (pd3) check("done3_one_cycle", 1, 0);
        check("latency3", cyc - tinit3, 7);
        if (q3.size() == 0) check("unexpected_done3", 1, 0);
        else begin
          last3 = q3.pop_front();
          check("result3", int'(res3), int'(last3));
        end
      end else check("hold3", int'(res3), int'(last3));
    end
    pb2 = busy2; pb3 = busy3; pd2 = done2; pd3 = done3;
  end

  initial begin
    resetn = 1'b0;
    go2 = 1'b0; go3 = 1'b0; din2 = '0; din3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_idx2", int'(li2), 0);
    check("rst_busy2", int'(busy2), 0);
    check("rst_done2", int'(done2), 0);
    check("rst_res2", int'(res2), 0);
    check("rst_idx3", int'(li3), 0);
    check("rst_busy3", int'(busy3), 0);
    check("rst_res3", int'(res3), 0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Basic evaluation
    set_c(1, 3, 2, 0); run(0, 5, 8'h42, 1, 1'b0);
    // Wrap-around
    set_c(0, 0, 16, 0); run(0, 16, 0, 2, 1'b0);
    set_c(255, 1, 0, 0); run(0, 1, 0, 1, 1'b0);
    // Degree 3
    set_c(1, 1, 1, 1); run(1, 2, 15, 1, 1'b0);
    // Long held go on c0, go toggled during compute
    set_c(7, 4, 9, 0); run(0, 3, -1, 20, 1'b1);
    // Back-to-back: previous result must hold through the next load
    set_c(1, 3, 2, 0); run(0, 5, 8'h42, 1, 1'b0);
    set_c(2, 0, 1, 0); run(0, 3, 11, 2, 1'b0);

    // Reset after c0, c1, with go asserted on the reset edge
    set_c(1, 3, 2, 0); run(0, 5, 8'h42, 1, 1'b0);
    wait_idle(0);
    press(0, 0, 8'd9, 1, 1);
    press(0, 1, 8'd8, 1, 1);
    @(posedge clk); #1;
    resetn = 1'b0; go2 = 1'b1; din2 = 8'd77;
    @(posedge clk); #1;
    last2 = 8'd0; last3 = 8'd0;
    check("rst_mid_idx", int'(li2), 0);
    check("rst_mid_res", int'(res2), 0);
    check("rst_mid_busy", int'(busy2), 0);
    check("rst_mid_done", int'(done2), 0);
    resetn = 1'b1; go2 = 1'b0;
    set_c(1, 3, 2, 0); run(0, 5, 8'h42, 1, 1'b0);

    // Randomized runs on both instances
    for (int r = 0; r < 12; r++) begin
      int d = int'($urandom_range(0, 1));
      set_c(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      run(d, int'($urandom_range(0, 255)), -1, int'($urandom_range(1, 6)),
          bit'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("q2_drained", q2.size(), 0);
    check("q3_drained", q3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
